// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, decode
// fields, ALU operation codes and the per-state control word.
package mips_ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned ALUCTL_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   // Opcodes (instr[31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   // R-type funct codes (instr[5:0])
   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   // ALUOp from the main FSM to the ALU decoder
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   // ALU control encodings seen by the datapath ALU
   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

   // Mux selects
   localparam logic [1:0] PCSRC_ALURES = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Moore control word held for the current state
   typedef struct packed {
      logic               mem_to_reg;
      logic               reg_dst;
      logic               i_or_d;
      logic [1:0]         pc_src;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic               ir_write;
      logic               mem_write;
      logic               pc_write;
      logic               branch;
      logic               reg_write;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // Control word for a given state; anything not set stays 0
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_b = SRCB_FOUR;
            c.pc_src    = PCSRC_ALURES;
            c.aluop     = ALUOP_ADD;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH2;
            c.aluop     = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.aluop     = ALUOP_ADD;
         end
         S_MEMRD: c.i_or_d = 1'b1;
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
         end
         S_RTYPEEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.aluop     = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BEQEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.aluop     = ALUOP_SUB;
            c.pc_src    = PCSRC_ALUOUT;
            c.branch    = 1'b1;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JEX: begin
            c.pc_src   = PCSRC_JUMP;
            c.pc_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Opcodes the FSM knows how to sequence
   function automatic logic op_supported(input logic [OP_W-1:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps ALUOp and R-type funct to the ALU operation code.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [ALUOP_W-1:0]  aluop,
   input  logic [FUNCT_W-1:0]  funct,
   output logic [ALUCTL_W-1:0] alu_control
);

   // Unknown funct and the unused ALUOp fall back to add
   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore main FSM with a registered control
// word plus the combinational ALU decoder.
module mips_mc_control_fsm
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OP_W-1:0]     opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                i_or_d,
   output logic [1:0]          pc_src,
   output logic                pc_en,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                ir_write,
   output logic                mem_write,
   output logic                pc_write,
   output logic                branch,
   output logic                reg_write,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                illegal
);

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl;
   logic   wr_ok;

   // Next-state selection; opcode only matters in DECODE and MEMADR
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_RTYPEEX;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JEX;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:  state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_nxt = S_MEMWB;
         S_RTYPEEX: state_nxt = S_RTYPEWB;
         S_ADDIEX:  state_nxt = S_ADDIWB;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // State and control word; the word is loaded for the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         ctrl  <= state_ctrl(S_FETCH);
      end else begin
         state <= state_nxt;
         ctrl  <= state_ctrl(state_nxt);
      end
   end

   // Enables are held off while in reset or in an unencoded state
   assign wr_ok = ~reset & (state <= S_JEX);

   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_dst    = ctrl.reg_dst;
   assign i_or_d     = ctrl.i_or_d;
   assign pc_src     = ctrl.pc_src;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign ir_write   = ctrl.ir_write  & wr_ok;
   assign mem_write  = ctrl.mem_write & wr_ok;
   assign pc_write   = ctrl.pc_write  & wr_ok;
   assign branch     = ctrl.branch    & wr_ok;
   assign reg_write  = ctrl.reg_write & wr_ok;
   assign pc_en      = (ctrl.pc_write | (ctrl.branch & zero)) & wr_ok;

   // Decode fault flag: the IR holds the new opcode only once in DECODE
   assign illegal = (state == S_DECODE) & ~op_supported(opcode) & wr_ok;

   mips_alu_decoder u_alu_dec (
      .aluop       (ctrl.aluop),
      .funct       (funct),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Directed bench for the multi-cycle MIPS control FSM.
module tb_mips_mc_control_fsm;

   localparam int S_FETCH   = 0;
   localparam int S_DECODE  = 1;
   localparam int S_MEMADR  = 2;
   localparam int S_MEMRD   = 3;
   localparam int S_MEMWB   = 4;
   localparam int S_MEMWR   = 5;
   localparam int S_RTYPEEX = 6;
   localparam int S_RTYPEWB = 7;
   localparam int S_BEQEX   = 8;
   localparam int S_ADDIEX  = 9;
   localparam int S_ADDIWB  = 10;
   localparam int S_JEX     = 11;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RTY  = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   typedef struct packed {
      logic       mem_to_reg;
      logic       reg_dst;
      logic       i_or_d;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ir_write;
      logic       mem_write;
      logic       pc_write;
      logic       branch;
      logic       reg_write;
      logic [2:0] alu_control;
      logic       illegal;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_to_reg, reg_dst, i_or_d, pc_en, alu_src_a;
   logic       ir_write, mem_write, pc_write, branch, reg_write, illegal;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_control;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   mips_mc_control_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_to_reg  (mem_to_reg),
      .reg_dst     (reg_dst),
      .i_or_d      (i_or_d),
      .pc_src      (pc_src),
      .pc_en       (pc_en),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .ir_write    (ir_write),
      .mem_write   (mem_write),
      .pc_write    (pc_write),
      .branch      (branch),
      .reg_write   (reg_write),
      .alu_control (alu_control),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   // Expected outputs for a state, built from the state/output table
   function automatic obs_t spec_out(input int st, input logic rst, input logic z,
                                     input logic [5:0] fn, input logic [5:0] op);
      obs_t o;
      logic [1:0] aluop;
      o = '0;
      aluop = 2'b00;
      case (st)
         S_FETCH:   begin o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1; end
         S_DECODE:  begin
            o.alu_src_b = 2'b11;
            o.illegal = !(op == LW || op == SW || op == RTY || op == BEQ ||
                          op == ADDI || op == JMP);
         end
         S_MEMADR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         S_MEMRD:   o.i_or_d = 1'b1;
         S_MEMWB:   begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
         S_MEMWR:   begin o.i_or_d = 1'b1; o.mem_write = 1'b1; end
         S_RTYPEEX: begin o.alu_src_a = 1'b1; aluop = 2'b10; end
         S_RTYPEWB: begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
         S_BEQEX:   begin o.alu_src_a = 1'b1; aluop = 2'b01; o.pc_src = 2'b01; o.branch = 1'b1; end
         S_ADDIEX:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         S_ADDIWB:  o.reg_write = 1'b1;
         S_JEX:     begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
         default:   o = '0;
      endcase
      if (rst) begin
         o.ir_write = 1'b0; o.pc_write = 1'b0; o.mem_write = 1'b0;
         o.reg_write = 1'b0; o.branch = 1'b0; o.illegal = 1'b0;
      end
      o.pc_en = o.pc_write | (o.branch & z);
      if (aluop == 2'b01) o.alu_control = 3'b110;
      else if (aluop == 2'b10) begin
         case (fn)
            6'b100000: o.alu_control = 3'b010;
            6'b100010: o.alu_control = 3'b110;
            6'b100100: o.alu_control = 3'b000;
            6'b100101: o.alu_control = 3'b001;
            6'b101010: o.alu_control = 3'b111;
            default:   o.alu_control = 3'b010;
         endcase
      end else o.alu_control = 3'b010;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.mem_to_reg = mem_to_reg; o.reg_dst = reg_dst; o.i_or_d = i_or_d;
      o.pc_src = pc_src; o.pc_en = pc_en; o.alu_src_a = alu_src_a;
      o.alu_src_b = alu_src_b; o.ir_write = ir_write; o.mem_write = mem_write;
      o.pc_write = pc_write; o.branch = branch; o.reg_write = reg_write;
      o.alu_control = alu_control; o.illegal = illegal;
      return o;
   endfunction

   task automatic compare(input string tag);
      obs_t e, got;
      e = exp_q.pop_front();
      got = sample();
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, e);
      end
   endtask

   // One clock in state st: push expectation, compare on the falling edge
   task automatic step(input int st, input string tag);
      exp_q.push_back(spec_out(st, reset, zero, funct, opcode));
      @(negedge clk);
      compare(tag);
      @(posedge clk);
      #1;
   endtask

   // Immediate check without waiting for an edge
   task automatic check_now(input int st, input string tag);
      #1;
      exp_q.push_back(spec_out(st, reset, zero, funct, opcode));
      compare(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] fn_tab [6];
      fn_tab[0] = 6'b101010; fn_tab[1] = 6'b100100; fn_tab[2] = 6'b100000;
      fn_tab[3] = 6'b100010; fn_tab[4] = 6'b100101; fn_tab[5] = 6'b000111;

      reset = 1'b1; opcode = RTY; funct = 6'b0; zero = 1'b0;
      @(posedge clk); #1;
      step(S_FETCH, "reset_hold0");
      step(S_FETCH, "reset_hold1");
      reset = 1'b0;

      // lw: 5 cycles, opcode changes after MEMADR must be ignored
      opcode = LW;
      step(S_FETCH,  "lw_fetch");
      step(S_DECODE, "lw_decode");
      step(S_MEMADR, "lw_memadr");
      opcode = BAD;
      step(S_MEMRD,  "lw_memrd");
      step(S_MEMWB,  "lw_memwb");

      // R-type over a funct table, including an unknown funct
      for (int i = 0; i < 6; i++) begin
         opcode = RTY; funct = fn_tab[i];
         step(S_FETCH,   "rt_fetch");
         step(S_DECODE,  "rt_decode");
         opcode = BAD;
         step(S_RTYPEEX, "rt_ex");
         step(S_RTYPEWB, "rt_wb");
      end
      funct = 6'b101010;

      // addi
      opcode = ADDI;
      step(S_FETCH,  "addi_fetch");
      step(S_DECODE, "addi_decode");
      opcode = LW;
      step(S_ADDIEX, "addi_ex");
      step(S_ADDIWB, "addi_wb");

      // beq taken then not taken
      opcode = BEQ; zero = 1'b1;
      step(S_FETCH,  "beq_t_fetch");
      step(S_DECODE, "beq_t_decode");
      step(S_BEQEX,  "beq_t_ex");
      zero = 1'b0;
      step(S_FETCH,  "beq_n_fetch");
      step(S_DECODE, "beq_n_decode");
      step(S_BEQEX,  "beq_n_ex");

      // jump
      opcode = JMP;
      step(S_FETCH,  "j_fetch");
      step(S_DECODE, "j_decode");
      opcode = SW;
      step(S_JEX,    "j_ex");

      // sw
      opcode = SW;
      step(S_FETCH,  "sw_fetch");
      step(S_DECODE, "sw_decode");
      step(S_MEMADR, "sw_memadr");
      opcode = LW;
      step(S_MEMWR,  "sw_memwr");

      // unsupported opcode: illegal pulse in DECODE, straight back to FETCH
      opcode = BAD;
      step(S_FETCH,  "bad_fetch");
      step(S_DECODE, "bad_decode");
      step(S_FETCH,  "bad_refetch");

      // reset asserted in the middle of MEMRD
      opcode = LW;
      step(S_DECODE, "rst_lw_decode");
      step(S_MEMADR, "rst_lw_memadr");
      #2 reset = 1'b1;
      check_now(S_FETCH, "rst_async");
      @(posedge clk); #1;
      step(S_FETCH,  "rst_held");
      reset = 1'b0;
      opcode = ADDI;
      step(S_FETCH,  "rst_rel_fetch");
      step(S_DECODE, "rst_rel_decode");
      step(S_ADDIEX, "rst_rel_ex");
      step(S_ADDIWB, "rst_rel_wb");
      step(S_FETCH,  "rst_rel_refetch");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
